seq_divider: RTL and testbench

- Sequential restoring divider: unsigned dp_width-bit dividend / dp_width-bit divisor.
- Produces quotient and remainder with a shift/trial-subtract datapath, one quotient bit per two clocks.
- It is the inverse companion to the shift-add sequential multiplier. It shares that block's start/rdy handshake and its observable-state style.
- Datapath registers are A (partial remainder), Q (dividend, becoming the quotient), B (divisor) and P (bit counter).

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_div_ctrl.sv | 71 +++++++
 rtl/seq_divider.sv | 84 ++++++++
 tb/tb_seq_divider.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared constants and state type for the sequential restoring divider
package seq_divider_pkg;

  localparam int dp_width = 5;
  localparam int bc_size  = 3;
  localparam int st_width = 2;

  typedef enum logic [st_width-1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_SUB   = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_div_ctrl.sv
// rtl/seq_divider_div_ctrl.sv - divider sequencer: FSM, bit counter and datapath strobes
module div_ctrl
  import seq_divider_pkg::*;
(
  input  logic                clk,
  input  logic                rstb,
  input  logic                start,
  input  logic                divisor_zero,
  output logic                load_regs,
  output logic                dbz_regs,
  output logic                shift_regs,
  output logic                sub_regs,
  output logic                zero,
  output logic                rdy,
  output logic [st_width-1:0] state,
  output logic [bc_size-1:0]  P
);

  state_t             state_q, state_d;
  logic [bc_size-1:0] p_q, p_d;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
    end
  end

  assign zero = (p_q == bc_size'(1));

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    load_regs  = 1'b0;
    dbz_regs   = 1'b0;
    shift_regs = 1'b0;
    sub_regs   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // A zero divisor is resolved in IDLE without running any iterations
          if (divisor_zero) begin
            dbz_regs = 1'b1;
          end else begin
            load_regs = 1'b1;
            p_d       = bc_size'(dp_width);
            state_d   = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        shift_regs = 1'b1;
        state_d    = S_SUB;
      end
      S_SUB: begin
        sub_regs = 1'b1;
        p_d      = p_q - 1'b1;
        state_d  = zero ? S_IDLE : S_SHIFT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rdy   = (state_q == S_IDLE);
  assign state = state_q;
  assign P     = p_q;

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - unsigned restoring divider, one quotient bit per two clocks
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic                clk,
  input  logic                rstb,
  input  logic                start,
  input  logic [dp_width-1:0] dividend,
  input  logic [dp_width-1:0] divisor,
  output logic [dp_width-1:0] quotient,
  output logic [dp_width-1:0] remainder,
  output logic                div_by_zero,
  output logic                rdy,
  output logic [st_width-1:0] state,
  output logic [bc_size-1:0]  P
);

  logic                load_regs, dbz_regs, shift_regs, sub_regs, zero;
  logic [dp_width:0]   a_q, a_d;
  logic [dp_width-1:0] q_q, q_d;
  logic [dp_width-1:0] b_q, b_d;
  logic                dbz_q, dbz_d;
  logic [dp_width+1:0] diff;

  div_ctrl u_ctrl (
    .clk          (clk),
    .rstb         (rstb),
    .start        (start),
    .divisor_zero (divisor == '0),
    .load_regs    (load_regs),
    .dbz_regs     (dbz_regs),
    .shift_regs   (shift_regs),
    .sub_regs     (sub_regs),
    .zero         (zero),
    .rdy          (rdy),
    .state        (state),
    .P            (P)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      a_q   <= '0;
      q_q   <= '0;
      b_q   <= '0;
      dbz_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      b_q   <= b_d;
      dbz_q <= dbz_d;
    end
  end

  // Sign bit of the widened trial difference tells whether B fits into A
  assign diff = {1'b0, a_q} - {2'b00, b_q};

  always_comb begin
    a_d   = a_q;
    q_d   = q_q;
    b_d   = b_q;
    dbz_d = dbz_q;
    if (load_regs) begin
      a_d   = '0;
      q_d   = dividend;
      b_d   = divisor;
      dbz_d = 1'b0;
    end else if (dbz_regs) begin
      a_d   = {1'b0, dividend};
      q_d   = '1;
      dbz_d = 1'b1;
    end else if (shift_regs) begin
      // A < B on entry, so A's top bit is zero and dropping it loses nothing
      {a_d, q_d} = {a_q[dp_width-1:0], q_q, 1'b0};
    end else if (sub_regs && !diff[dp_width+1]) begin
      a_d    = diff[dp_width:0];
      q_d[0] = 1'b1;
    end
  end

  assign quotient    = q_q;
  assign remainder   = a_q[dp_width-1:0];
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider against an arithmetic model
module tb_seq_divider;
  import seq_divider_pkg::*;

  logic                clk = 1'b0;
  logic                rstb = 1'b0;
  logic                start = 1'b0;
  logic [dp_width-1:0] dividend = '0;
  logic [dp_width-1:0] divisor = '0;
  logic [dp_width-1:0] quotient, remainder;
  logic                div_by_zero, rdy;
  logic [st_width-1:0] state;
  logic [bc_size-1:0]  P;

  int n_vec = 0;
  int n_err = 0;

  seq_divider dut (
    .clk         (clk),
    .rstb        (rstb),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .rdy         (rdy),
    .state       (state),
    .P           (P)
  );

  always #5 clk = ~clk;

  // Expected {quotient, remainder, div_by_zero} from plain integer arithmetic
  function automatic logic [10:0] model(input int a, input int b);
    if (b == 0) return {5'h1f, 5'(a), 1'b1};
    return {5'(a / b), 5'(a % b), 1'b0};
  endfunction

  function automatic int model_lat(input int b);
    return (b == 0) ? 0 : 2 * dp_width;
  endfunction

  // Issue one start pulse, scramble operands afterwards, count edges after T0 until rdy
  task automatic do_op(input logic [4:0] a, input logic [4:0] b, output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 5'($urandom);
    divisor  = 5'($urandom);
    lat = 0;
    while (rdy !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    #12;
    n_vec++;
    if ({rdy, state, P, quotient, remainder, div_by_zero} !== {1'b1, 2'd0, 3'd0, 5'd0, 5'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: got rdy=%b st=%0d P=%0d q=%0d r=%0d dbz=%b want 1/0/0/0/0/0",
               rdy, state, P, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rstb = 1'b1;
  endtask

  task automatic test_op(input string name, input int a, input int b);
    int lat;
    logic [10:0] exp;
    exp = model(a, b);
    do_op(5'(a), 5'(b), lat);
    n_vec++;
    if (lat !== model_lat(b)) begin
      n_err++;
      $display("FAIL %s_latency %0d/%0d: got %0d want %0d", name, a, b, lat, model_lat(b));
    end
    n_vec++;
    if ({quotient, remainder, div_by_zero} !== exp) begin
      n_err++;
      $display("FAIL %s_result %0d/%0d: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
               name, a, b, quotient, remainder, div_by_zero, exp[10:6], exp[5:1], exp[0]);
    end
  endtask

  task automatic test_basic();
    test_op("basic", 23, 19);
    test_op("div_by_one", 31, 1);
    test_op("equal", 31, 31);
    test_op("small_dividend", 5, 7);
  endtask

  task automatic test_div_zero();
    test_op("div_zero", 13, 0);
    test_op("after_zero", 7, 2);
  endtask

  task automatic test_back_to_back();
    int highs;
    highs = 0;
    @(negedge clk);
    dividend = 5'd14;
    divisor  = 5'd3;
    start    = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin
        highs++;
        n_vec++;
        if ({quotient, remainder} !== {5'd4, 5'd2}) begin
          n_err++;
          $display("FAIL b2b_result at %0d: got q=%0d r=%0d want q=4 r=2", i, quotient, remainder);
        end
      end
    end
    start = 1'b0;
    n_vec++;
    if (highs !== 2) begin
      n_err++;
      $display("FAIL b2b_rdy_cycles: got %0d want 2", highs);
    end
    // The third operation was accepted while start was still high; let it drain
    for (int i = 0; i < 40 && rdy !== 1'b1; i++) @(negedge clk);
    n_vec++;
    if ({rdy, quotient, remainder} !== {1'b1, 5'd4, 5'd2}) begin
      n_err++;
      $display("FAIL b2b_drain: got rdy=%b q=%0d r=%0d want 1/4/2", rdy, quotient, remainder);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    dividend = 5'd23;
    divisor  = 5'd19;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    repeat (3) begin
      @(posedge clk);
      lat++;
    end
    @(negedge clk);
    dividend = 5'd31;
    divisor  = 5'd1;
    start    = 1'b1;
    @(posedge clk);
    lat++;
    #1;
    start = 1'b0;
    while (rdy !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
    n_vec++;
    if (lat !== 2 * dp_width) begin
      n_err++;
      $display("FAIL busy_latency: got %0d want %0d", lat, 2 * dp_width);
    end
    n_vec++;
    if ({quotient, remainder, div_by_zero} !== model(23, 19)) begin
      n_err++;
      $display("FAIL busy_result: got q=%0d r=%0d dbz=%b want q=1 r=4 dbz=0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    dividend = 5'd23;
    divisor  = 5'd19;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rstb = 1'b0;
    #1;
    n_vec++;
    if ({rdy, state, P, quotient, remainder, div_by_zero} !== {1'b1, 2'd0, 3'd0, 5'd0, 5'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid: got rdy=%b st=%0d P=%0d q=%0d r=%0d dbz=%b want 1/0/0/0/0/0",
               rdy, state, P, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rstb = 1'b1;
    test_op("after_reset", 23, 19);
  endtask

  task automatic test_random();
    int a, b;
    for (int i = 0; i < 30; i++) begin
      a = int'($urandom_range(0, 31));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
      test_op("random", a, b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
